// File: rtl/apb_uart_master.sv
// apb_uart_master: APB4 initiator turning a valid/ready command stream into
// one SETUP+ACCESS transfer per command, with exactly one response per command.
// Optional feature macro: APB_UART_MASTER_TIMEOUT_EN (ACCESS wait-state timeout).
// Ports:
//   pclk, preset        clock, synchronous active-high reset
//   cmd_*               command request stream (valid/ready)
//   rsp_*               response stream (valid/ready), rsp_timeout flags aborts
//   busy                transfer or response outstanding
//   psel..pstrb         APB request outputs; pready/pslverr/prdata completer inputs
module apb_uart_master #(
  parameter int unsigned ADDR_W         = 12,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                pclk,
  input  logic                preset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_timeout,
  output logic                busy,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [ADDR_W-1:0]   paddr,
  output logic [DATA_W-1:0]   pwdata,
  output logic [DATA_W/8-1:0] pstrb,
  input  logic                pready,
  input  logic                pslverr,
  input  logic [DATA_W-1:0]   prdata
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned CNT_W  = 16;

  // Elaboration-time parameter legality check
  if (DATA_W != 32 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("apb_uart_master: DATA_W must be 32 and TIMEOUT_CYCLES in 1..65535");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t              state, state_d;
  logic                psel_d, penable_d, pwrite_d;
  logic [ADDR_W-1:0]   paddr_d;
  logic [DATA_W-1:0]   pwdata_d;
  logic [STRB_W-1:0]   pstrb_d;
  logic                rsp_valid_d, rsp_err_d, rsp_timeout_d;
  logic [DATA_W-1:0]   rsp_rdata_d;

`ifdef APB_UART_MASTER_TIMEOUT_EN
  logic [CNT_W-1:0]    wait_cnt, wait_cnt_d;
  logic                rsp_timeout_q;
`endif

  // Command-side handshake and status decoded straight from state
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Next-state and next-output logic
  always_comb begin
    state_d       = state;
    psel_d        = psel;
    penable_d     = penable;
    pwrite_d      = pwrite;
    paddr_d       = paddr;
    pwdata_d      = pwdata;
    pstrb_d       = pstrb;
    rsp_valid_d   = rsp_valid;
    rsp_err_d     = rsp_err;
    rsp_rdata_d   = rsp_rdata;
    rsp_timeout_d = rsp_timeout;
`ifdef APB_UART_MASTER_TIMEOUT_EN
    wait_cnt_d    = wait_cnt;
`endif
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_addr[1:0] != 2'b00) begin
            // Misaligned: answer with an error without touching the bus
            state_d       = RESP;
            rsp_valid_d   = 1'b1;
            rsp_err_d     = 1'b1;
            rsp_rdata_d   = '0;
            rsp_timeout_d = 1'b0;
          end else begin
            state_d   = SETUP;
            psel_d    = 1'b1;
            penable_d = 1'b0;
            pwrite_d  = cmd_write;
            paddr_d   = cmd_addr;
            pwdata_d  = cmd_write ? cmd_wdata : '0;
            pstrb_d   = cmd_write ? cmd_strb  : '0;
          end
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
`ifdef APB_UART_MASTER_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      ACCESS: begin
        if (pready) begin
          // Completion wins over a timeout hitting in the same cycle
          state_d       = RESP;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = pslverr;
          rsp_rdata_d   = (!pwrite && !pslverr) ? prdata : '0;
          rsp_timeout_d = 1'b0;
        end
`ifdef APB_UART_MASTER_TIMEOUT_EN
        else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // This cycle is the TIMEOUT_CYCLES-th wait: abandon the transfer
          state_d       = RESP;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt + CNT_W'(1);
        end
`endif
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge pclk) begin
    if (preset) begin
      state     <= IDLE;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      pstrb     <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_d;
      psel      <= psel_d;
      penable   <= penable_d;
      pwrite    <= pwrite_d;
      paddr     <= paddr_d;
      pwdata    <= pwdata_d;
      pstrb     <= pstrb_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_rdata <= rsp_rdata_d;
    end
  end

`ifdef APB_UART_MASTER_TIMEOUT_EN
  // Wait-state counter and timeout flag
  always_ff @(posedge pclk) begin
    if (preset) begin
      wait_cnt      <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      wait_cnt      <= wait_cnt_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end
  assign rsp_timeout = rsp_timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_apb_uart_master.sv
// tb_apb_uart_master: self-checking bench for apb_uart_master. Expected
// responses are queued when a command is issued and compared at the response
// handshake; cycle-accurate APB timing is checked inline.
// Build with APB_UART_MASTER_TIMEOUT_EN defined to exercise the timeout path.
module tb_apb_uart_master;

  logic        pclk = 1'b0;
  logic        preset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout, busy;
  logic [31:0] rsp_rdata;
  logic        psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready, pslverr;
  logic [31:0] prdata;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  apb_uart_master #(.ADDR_W(12), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready), .pslverr(pslverr), .prdata(prdata)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle away from the edge
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Present one command for one accepting edge; returns after that edge
  task automatic issue(input logic w, input logic [11:0] a, input logic [31:0] wd,
                       input logic [3:0] s);
    int n = 0;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    check("issue_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = wd; cmd_strb = s;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Wait (bounded) for a response, compare to scoreboard, complete handshake
  task automatic get_rsp(input string tag);
    exp_t e;
    int n = 0;
    while (!rsp_valid && n < 50) begin tick(); n++; end
    check({tag, "_vld"}, 32'(rsp_valid), 32'd1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    check({tag, "_rdata"}, rsp_rdata, e.rdata);
    check({tag, "_err"}, 32'(rsp_err), 32'(e.err));
    check({tag, "_tmo"}, 32'(rsp_timeout), 32'(e.tmo));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, "_done"}, {30'd0, rsp_valid, cmd_ready}, 32'b01);
  endtask

  initial begin
    preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_strb = '0; rsp_ready = 1'b0;
    pready = 1'b1; pslverr = 1'b0; prdata = '0;
    tick(); tick();
    preset = 1'b0;

    // Reset state
    check("rst_apb", {28'd0, psel, penable, pwrite, |pstrb}, 32'd0);
    check("rst_paddr", 32'(paddr), 32'd0);
    check("rst_rsp", {29'd0, rsp_valid, rsp_err, rsp_timeout}, 32'd0);
    check("rst_ready_busy", {30'd0, cmd_ready, busy}, 32'b10);

    // Write, no wait states
    exp_q.push_back('{rdata: 32'd0, err: 1'b0, tmo: 1'b0});
    issue(1'b1, 12'h004, 32'h0000_0055, 4'hF);
    check("wr_setup", {30'd0, psel, penable}, 32'b10);
    check("wr_paddr", 32'(paddr), 32'h004);
    check("wr_pstrb", 32'(pstrb), 32'hF);
    check("wr_pwdata", pwdata, 32'h55);
    check("wr_busy", {30'd0, cmd_ready, busy}, 32'b01);
    tick();
    check("wr_access", {29'd0, psel, penable, pwrite}, 32'b111);
    tick();
    check("wr_t3", {30'd0, psel, rsp_valid}, 32'b01);
    get_rsp("wr");

    // Read with three wait states
    pready = 1'b0;
    exp_q.push_back('{rdata: 32'h0000_00A5, err: 1'b0, tmo: 1'b0});
    issue(1'b0, 12'h008, 32'hFFFF_FFFF, 4'hF);
    check("rd_setup", {30'd0, psel, penable}, 32'b10);
    check("rd_pwdata", pwdata, 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rd_wait%0d", i), {18'd0, psel, penable, pwrite, pstrb, rsp_valid, paddr[7:0]},
            {18'd0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 8'h08});
      if (i < 3) tick();
    end
    pready = 1'b1; prdata = 32'h0000_00A5;
    tick();
    check("rd_t6", 32'(rsp_valid), 32'd1);
    prdata = 32'd0;
    get_rsp("rd");

    // Slave error on a read
    pslverr = 1'b1; prdata = 32'hDEAD_BEEF;
    exp_q.push_back('{rdata: 32'd0, err: 1'b1, tmo: 1'b0});
    issue(1'b0, 12'h010, 32'd0, 4'h0);
    get_rsp("slverr");
    pslverr = 1'b0; prdata = 32'd0;

    // Misaligned address never reaches the bus
    exp_q.push_back('{rdata: 32'd0, err: 1'b1, tmo: 1'b0});
    issue(1'b1, 12'h006, 32'h1234_5678, 4'hF);
    check("mis_t1", {30'd0, psel, rsp_valid}, 32'b01);
    get_rsp("mis");

    // Response back-pressure with an ignored second command
    exp_q.push_back('{rdata: 32'd0, err: 1'b0, tmo: 1'b0});
    issue(1'b1, 12'h00C, 32'h0000_00C3, 4'h3);
    tick(); tick();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h020; cmd_wdata = 32'hAAAA_AAAA;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_hold%0d", i), {27'd0, rsp_valid, rsp_err, |rsp_rdata, cmd_ready, psel},
            32'b10000);
      tick();
    end
    cmd_valid = 1'b0;
    get_rsp("bp");
    tick(); tick();
    check("bp_ignored", {29'd0, psel, rsp_valid, busy}, 32'd0);
    check("bp_paddr", 32'(paddr), 32'h00C);

    // Reset during ACCESS drops the transfer with no response
    pready = 1'b0;
    issue(1'b0, 12'h014, 32'd0, 4'h0);
    tick(); tick();
    check("rst_mid_access", {30'd0, psel, penable}, 32'b11);
    preset = 1'b1;
    tick();
    preset = 1'b0; pready = 1'b1;
    check("rst_mid_drop", {28'd0, psel, penable, rsp_valid, busy}, 32'd0);
    tick(); tick(); tick();
    check("rst_mid_norsp", {30'd0, rsp_valid, psel}, 32'd0);

`ifdef APB_UART_MASTER_TIMEOUT_EN
    // Timeout after four ACCESS wait cycles
    begin
      int waits = 0;
      pready = 1'b0;
      exp_q.push_back('{rdata: 32'd0, err: 1'b1, tmo: 1'b1});
      issue(1'b0, 12'h018, 32'd0, 4'h0);
      tick();
      while (psel && waits < 20) begin waits++; tick(); end
      check("tmo_waits", 32'(waits), 32'd4);
      check("tmo_drop", {30'd0, psel, penable}, 32'd0);
      get_rsp("tmo");
    end
    // pready on the limit cycle completes normally
    exp_q.push_back('{rdata: 32'h1234_5678, err: 1'b0, tmo: 1'b0});
    issue(1'b0, 12'h01C, 32'd0, 4'h0);
    tick(); tick(); tick(); tick();
    check("tmo_edge_psel", 32'(psel), 32'd1);
    pready = 1'b1; prdata = 32'h1234_5678;
    tick();
    get_rsp("tmo_edge");
`else
    // Without the timeout feature ACCESS waits indefinitely
    begin
      int held = 0;
      pready = 1'b0;
      exp_q.push_back('{rdata: 32'h1234_5678, err: 1'b0, tmo: 1'b0});
      issue(1'b0, 12'h01C, 32'd0, 4'h0);
      tick();
      for (int i = 0; i < 1000; i++) begin
        if (psel && penable && !rsp_valid) held++;
        tick();
      end
      check("notmo_pending", 32'(held), 32'd1000);
      pready = 1'b1; prdata = 32'h1234_5678;
      get_rsp("notmo");
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/apb_uart_master.md
Name: apb_uart_master

Overview:
- APB initiator that drives the UART's APB slave port (or any 12-bit-address APB4 completer) from a simple valid/ready command stream.
- One command becomes one APB transfer (SETUP then ACCESS). Wait states and pslverr are handled, and a single response is returned per command.
- Sits between firmware-side/test-sequencer logic and the apb_uart register file. This is the requester end of the same bus.

Parameters:
- ADDR_W, 12, APB address width.
- DATA_W, 32, APB data width; must be 32.
- TIMEOUT_CYCLES, 256, max ACCESS cycles with pready=0 before abort (timeout feature only); legal range 1..65535.

Ports:
- pclk  in  1  system clock.
- preset  in  1  synchronous active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  master can accept command.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_W  byte address.
- cmd_wdata  in  32  write data.
- cmd_strb  in  4  write byte strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  32  read data (0 for writes and errors).
- rsp_err  out  1  pslverr, misalignment or timeout.
- rsp_timeout  out  1  response caused by timeout.
- busy  out  1  state != IDLE.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_W  APB address.
- pwdata  out  32  APB write data.
- pstrb  out  4  APB strobes.
- pready  in  1  completer ready.
- pslverr  in  1  completer error.
- prdata  in  32  completer read data.

Behaviour:
- Clock and reset:
  - Single clock pclk; reset preset is synchronous, active-high.
  - All outputs are registered except cmd_ready and busy, which are decoded from state.
- Reset values:
  - state=IDLE.
  - psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, pstrb=0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0.
  - cmd_ready=1, busy=0.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1. Accept on cmd_valid at edge T and latch all cmd_* fields.
  - If cmd_addr[1:0]!=0: no APB transfer; go RESP with rsp_err=1, rsp_rdata=0.
  - Otherwise go SETUP: at T+1, psel=1, penable=0, paddr/pwrite/pwdata valid.
  - pstrb=cmd_strb for writes, 4'b0000 for reads; pwdata=0 for reads.
- SETUP: always exactly one cycle. Next: penable=1 (ACCESS).
- ACCESS:
  - All APB outputs held stable while pready=0.
  - On pready=1 at edge E:
    - psel=0, penable=0 at E+1; paddr/pwdata/pstrb/pwrite keep last value.
    - rsp_valid=1 at E+1.
    - rsp_err=pslverr.
    - rsp_rdata=prdata for reads without pslverr, else 0.
  - Then go RESP.
- Minimum latency: command accepted T, pready high at T+2, rsp_valid at T+3.
- RESP:
  - rsp_* held stable until rsp_valid & rsp_ready; then rsp_valid=0 and go IDLE.
  - cmd_ready=0 in SETUP/ACCESS/RESP, so only one command is outstanding.
  - Next command can be accepted the cycle after the response handshake.
- Bus hygiene:
  - penable is never 1 while psel=0.
  - psel never deasserts in ACCESS before pready, except on timeout or reset.
- Reset mid-transfer: psel/penable/rsp_valid drop at the reset edge; the pending command is discarded and no response is produced.
- rsp_ready high while rsp_valid=0: ignored.
- cmd_valid while busy: ignored, not latched.

Optional Feature:
- Macro: APB_UART_MASTER_TIMEOUT_EN.
- Defined:
  - 16-bit wait counter cleared on entering ACCESS, incremented each ACCESS cycle with pready=0.
  - When counter reaches TIMEOUT_CYCLES with pready still 0: psel=0, penable=0 next cycle.
  - Response is rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0; go RESP.
  - pready=1 in the same cycle as the limit wins: normal completion.
- Undefined: no counter; ACCESS waits indefinitely; rsp_timeout is tied to 0.

Test Plan:
- Write, no wait:
  - Stimulus: cmd write addr 0x004, wdata 0x0000_0055, strb 0xF, pready=1.
  - Required: psel at T+1, penable at T+2, paddr=0x004, pstrb=0xF; rsp_valid at T+3 with rsp_err=0, rsp_rdata=0.
- Read with 3 wait states:
  - Stimulus: cmd read addr 0x008; pready low 3 ACCESS cycles, then prdata=0x0000_00A5.
  - Required: pstrb=0 throughout, APB signals stable while waiting; rsp_rdata=0xA5 at T+6.
- Slave error:
  - Stimulus: read 0x010 with pslverr=1, prdata=0xDEAD_BEEF.
  - Required: rsp_err=1, rsp_rdata=0.
- Misaligned address:
  - Stimulus: cmd addr 0x006.
  - Required: psel never asserts; rsp_valid at T+1, rsp_err=1.
- Back-pressure and reset:
  - Stimulus: hold rsp_ready=0 for 5 cycles.
  - Required: response stable, cmd_ready=0, second cmd_valid ignored.
  - Stimulus: then assert preset during a later ACCESS.
  - Required: psel=0 and rsp_valid=0 next edge.
- Timeout (macro defined, TIMEOUT_CYCLES=4):
  - Stimulus: pready held 0.
  - Required: psel drops after 4 ACCESS wait cycles; rsp_err=1, rsp_timeout=1.
  - Stimulus: repeat with macro undefined.
  - Required: transfer still pending after 1000 cycles.
